// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions: opcodes, forwarding defaults and result latencies.
// Decode uses opcode_t and issue_lat_for() to drive the scoreboard's ISSUE_LAT.
package otter_pkg;

    localparam int NFWD_DEFAULT = 2;
    localparam int FWD_RF       = 0;
    localparam int LAT_ALU      = 1;
    localparam int LAT_LOAD     = 2;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    function automatic int issue_lat_for(opcode_t op);
        return (op == OP_LOAD) ? LAT_LOAD : LAT_ALU;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: tracks whether a register has a write in flight,
// how many cycles ago it issued, and when its result becomes forwardable.
module hazard_sb_entry
    import otter_pkg::*;
#(
    parameter int NFWD = NFWD_DEFAULT,
    parameter int SELW = $clog2(NFWD + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_hit,
    input  logic [SELW-1:0] issue_lat,
    output logic            busy,
    output logic            ready,
    output logic [SELW-1:0] age
);

    logic            busy_q;
    logic [SELW:0]   age_q;
    logic [SELW-1:0] lat_q;

    // Only the busy bit needs reset; age and lat are ignored while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else if (issue_hit) begin
            busy_q <= 1'b1;
        end else if (busy_q && age_q == (SELW+1)'(NFWD)) begin
            busy_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_hit) begin
            age_q <= (SELW+1)'(1);
            lat_q <= issue_lat;
        end else if (busy_q) begin
            age_q <= age_q + (SELW+1)'(1);
        end
    end

    assign busy  = busy_q;
    assign ready = !busy_q || ({1'b0, lat_q} <= age_q);
    // Age never exceeds NFWD while busy, so it fits the select width.
    assign age   = age_q[SELW-1:0];

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register RAW hazard scoreboard: decides issue/stall for the decode-stage
// instruction and picks the forwarding source for each operand.
module hazard_scoreboard
    import otter_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NFWD   = NFWD_DEFAULT,
    parameter int REG_AW = $clog2(NREGS),
    parameter int SELW   = $clog2(NFWD + 1)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       ISSUE_VALID,
    input  logic                       FLUSH,
    input  logic                       ISSUE_USES_RS1,
    input  logic                       ISSUE_USES_RS2,
    input  logic [REG_AW-1:0]          ISSUE_RS1,
    input  logic [REG_AW-1:0]          ISSUE_RS2,
    input  logic                       ISSUE_RD_WE,
    input  logic [REG_AW-1:0]          ISSUE_RD,
    input  logic [SELW-1:0]            ISSUE_LAT,
    output logic                       STALL,
    output logic                       ISSUE_ACCEPT,
    output logic [SELW-1:0]            FWD_SEL_RS1,
    output logic [SELW-1:0]            FWD_SEL_RS2,
    output logic [$clog2(NREGS+1)-1:0] PENDING,
    output logic [31:0]                STALL_COUNT
);

    localparam int PW = $clog2(NREGS + 1);

    logic [NREGS-1:1] ent_busy;
    logic [NREGS-1:1] ent_ready;
    logic [NREGS-1:1] ent_hit;
    logic [SELW-1:0]  ent_age [NREGS-1:1];
    logic [SELW-1:0]  eff_lat;

    logic            rs1_busy, rs1_ready, rs2_busy, rs2_ready;
    logic [SELW-1:0] rs1_age, rs2_age;
    logic            use1, use2, not_ready1, not_ready2, live;
    logic [PW-1:0]   busy_cnt;

    always_comb begin
        if (ISSUE_LAT == '0)
            eff_lat = SELW'(1);
        else if (int'(ISSUE_LAT) > NFWD)
            eff_lat = SELW'(NFWD);
        else
            eff_lat = ISSUE_LAT;
    end

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        assign ent_hit[r] = ISSUE_ACCEPT && ISSUE_RD_WE && (ISSUE_RD == REG_AW'(r));

        hazard_sb_entry #(
            .NFWD (NFWD),
            .SELW (SELW)
        ) u_entry (
            .clk       (CLK),
            .rst_n     (RST_N),
            .issue_hit (ent_hit[r]),
            .issue_lat (eff_lat),
            .busy      (ent_busy[r]),
            .ready     (ent_ready[r]),
            .age       (ent_age[r])
        );
    end

    // x0 has no entry, so an RS of zero falls through to "idle and ready".
    always_comb begin
        rs1_busy  = 1'b0;
        rs1_ready = 1'b1;
        rs1_age   = '0;
        rs2_busy  = 1'b0;
        rs2_ready = 1'b1;
        rs2_age   = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (ISSUE_RS1 == REG_AW'(r)) begin
                rs1_busy  = ent_busy[r];
                rs1_ready = ent_ready[r];
                rs1_age   = ent_age[r];
            end
            if (ISSUE_RS2 == REG_AW'(r)) begin
                rs2_busy  = ent_busy[r];
                rs2_ready = ent_ready[r];
                rs2_age   = ent_age[r];
            end
        end
    end

    assign use1       = ISSUE_USES_RS1 && (ISSUE_RS1 != '0);
    assign use2       = ISSUE_USES_RS2 && (ISSUE_RS2 != '0);
    assign not_ready1 = use1 && !rs1_ready;
    assign not_ready2 = use2 && !rs2_ready;
    assign live       = RST_N && ISSUE_VALID && !FLUSH;

    assign STALL        = live && (not_ready1 || not_ready2);
    assign ISSUE_ACCEPT = live && !(not_ready1 || not_ready2);
    assign FWD_SEL_RS1  = (RST_N && use1 && rs1_busy && rs1_ready) ? rs1_age : SELW'(FWD_RF);
    assign FWD_SEL_RS2  = (RST_N && use2 && rs2_busy && rs2_ready) ? rs2_age : SELW'(FWD_RF);

    always_comb begin
        busy_cnt = '0;
        for (int r = 1; r < NREGS; r++)
            busy_cnt = busy_cnt + PW'(ent_busy[r]);
    end

    assign PENDING = RST_N ? busy_cnt : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            STALL_COUNT <= '0;
        else if (STALL && STALL_COUNT != 32'hFFFF_FFFF)
            STALL_COUNT <= STALL_COUNT + 32'd1;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised read-after-write hazard and forwarding controller for the OTTER in-order pipeline. It replaces the fixed two-source forwarding and load-use stall logic with a per-register scoreboard. The scoreboard tracks every in-flight register write and its age, plus the result latency the issuing instruction declared. It sits between decode and execute: it decides whether the decode-stage instruction may issue, and which forwarding source feeds each operand mux.

## Interface
- NREGS, 32, architectural register count; register 0 hardwired zero, never tracked
- NFWD, 2, number of forwarding sources; source k holds a result k cycles after its producer issued (default: 1 = EX/MEM, 2 = MEM/WB)
- REG_AW, $clog2(NREGS), register address width (derived)
- SELW, $clog2(NFWD+1), forward-select and latency width (derived)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  synchronous reset, active-low
- ISSUE_VALID  in  1  decode holds a valid instruction
- FLUSH  in  1  decode instruction is being killed (taken branch/jump)
- ISSUE_USES_RS1, ISSUE_USES_RS2  in  1  operand actually read
- ISSUE_RS1, ISSUE_RS2  in  REG_AW  source register addresses
- ISSUE_RD_WE  in  1  instruction writes a register
- ISSUE_RD  in  REG_AW  destination register
- ISSUE_LAT  in  SELW  cycles after issue at which the result first appears on a forward source (ALU 1, LOAD 2)
- STALL  out  1  hold PC, IF and DE registers; insert bubble into EX
- ISSUE_ACCEPT  out  1  instruction moves to EX this cycle
- FWD_SEL_RS1, FWD_SEL_RS2  out  SELW  0 = register file, k = forward source k
- PENDING  out  $clog2(NREGS+1)  number of busy entries
- STALL_COUNT  out  32  saturating count of stall cycles

## Operation
- Per register r (1..NREGS-1), the entry holds busy, age (SELW+1 bits) and lat (SELW bits).
- Effective latency: ISSUE_LAT clamped; 0 treated as 1, values > NFWD treated as NFWD.
- Operand check, per operand i with USES_i=1, RS_i≠0 and entry busy:
  - age < lat: operand not ready.
  - otherwise: FWD_SEL_i = age.
- Unused operands, x0, and non-busy entries give FWD_SEL_i = 0 and are never "not ready".
- STALL = ISSUE_VALID & !FLUSH & any operand not ready.
- ISSUE_ACCEPT = ISSUE_VALID & !FLUSH & !STALL.
- Entry update each cycle; rules are in priority order:
  1. ISSUE_ACCEPT & ISSUE_RD_WE & ISSUE_RD≠0 → entry ISSUE_RD: busy=1, age=1, lat=effective latency. This also covers WAW: the newer write replaces the older one.
  2. Otherwise a busy entry with age = NFWD → busy=0, because the value is now in the register file. The register file is write-through, so a same-cycle write is visible on read.
  3. Otherwise a busy entry → age+1.
- Entries age during stalls too; this is what releases the stall.
- Operand checks use pre-update state. An instruction reading its own RD sees the older producer.
- STALL_COUNT increments on every cycle with STALL=1 and saturates at 0xFFFF_FFFF.
- PENDING is the combinational popcount of busy.

## Timing
- STALL, ISSUE_ACCEPT, FWD_SEL_* and PENDING are combinational from registered state plus the same-cycle issue inputs. There are no internal combinational loops.
- Producer accepted at cycle t with latency L:
  - Dependent in DE at t+a, a<L: stalls.
  - At t+a with L≤a≤NFWD: forwards from source a.
  - At t+NFWD+1 and later: reads the register file.
- Worst case: a dependent stalls for L-1 cycles.
- Reset: while RST_N=0 the block clears all busy bits and STALL_COUNT on the clock edge. During reset STALL, ISSUE_ACCEPT, FWD_SEL_* and PENDING are forced to 0.
- Reset mid-operation discards all in-flight tracking. The first cycle after reset sees an empty scoreboard.
- A FLUSH in the same cycle as a would-be stall gives STALL=0 and ISSUE_ACCEPT=0. No entry is created, and existing entries still age.

## Structure
- Shared package otter_pkg holds:
  - NFWD_DEFAULT = 2.
  - FWD_RF = 0.
  - LAT_ALU = 1.
  - LAT_LOAD = 2.
  - The existing opcode_t, which decode uses to derive ISSUE_LAT.
- Sub-module hazard_sb_entry: one register's busy/age/lat state and update rule. It has an issue-hit input and exposes ready/age.
- The top level does the following:
  - Generates NREGS-1 instances of hazard_sb_entry.
  - Muxes entries by RS1/RS2.
  - Implements the stall/accept logic and the counters.

## Test plan
- ALU dependency: NFWD=2. Issue add x5 (LAT=1) at t; at t+1 add x6,x5,x5 → STALL=0, FWD_SEL_RS1=FWD_SEL_RS2=1. At t+2 an independent instruction; at t+3 a reader of x5 → FWD_SEL=0.
- Load-use: lw x7 (LAT=2) at t; a reader of x7 at t+1 → STALL=1 for one cycle, STALL_COUNT=1. At t+2 → ISSUE_ACCEPT=1, FWD_SEL_RS1=2.
- x0 and unused operands: instructions writing x0, or with USES_RS2=0 on a busy RS2 → never stall, FWD_SEL=0, PENDING unchanged.
- WAW plus flush:
  - Step 1: lw x8 at t, then add x8 (LAT=1) at t+1. A reader at t+2 gives FWD_SEL=1 and no stall.
  - Step 2: repeat step 1 with FLUSH on the add. The reader then stalls against the load until t+2 and forwards from 2.
- Deep pipe: NFWD=4, LAT=3 producer. Readers at t+1 and t+2 stall; readers at t+3 and t+4 see FWD_SEL=3 and 4; t+5 sees 0. ISSUE_LAT=7 is clamped to 4.
- Reset mid-stall: hold RST_N=0 for one cycle during a load-use stall → the next cycle has STALL=0, PENDING=0, STALL_COUNT=0.
